// File: rtl/eflash_read_seq.sv
// eFlash read sequencer: one (rbr) or two (parallel) sense phases, buffer write strobes,
// a single encoder read cycle, then the captured 7-bit result with a one-cycle valid pulse.
module eflash_read_seq #(
    parameter int SENSE_CYCLES = 4,
    parameter int CNT_W        = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       mode_i,
    input  logic [6:0] encoder_output_i,
    output logic       busy_o,
    output logic       mode_o,
    output logic       sense_en_o,
    output logic       col_sel_o,
    output logic       buf_write_en_1_o,
    output logic       buf_write_en_2_o,
    output logic       buf_read_en_o,
    output logic [6:0] result_o,
    output logic       result_valid_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SENSE1,
        ST_SENSE2,
        ST_READ,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SENSE_CYCLES - 1);

    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic             mode_reg,   mode_next;
    logic [6:0]       result_reg, result_next;
    logic             last_cycle;

    // The sensed word is only valid in the final cycle of each sense phase.
    assign last_cycle = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            mode_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            mode_reg   <= mode_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mode_next   = mode_reg;
        result_next = result_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (start_i && !abort_i) begin
                    state_next = ST_SENSE1;
                    mode_next  = mode_i;
                end
            end
            ST_SENSE1: begin
                if (abort_i) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (last_cycle) begin
                    state_next = mode_reg ? ST_SENSE2 : ST_READ;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_SENSE2: begin
                if (abort_i) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (last_cycle) begin
                    state_next = ST_READ;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_READ: begin
                state_next = abort_i ? ST_IDLE : ST_DONE;
                if (!abort_i) begin
                    result_next = encoder_output_i;
                end
            end
            ST_DONE: begin
                // An abort here changes nothing: the pulse is already committed.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o           = (state_reg != ST_IDLE);
        mode_o           = mode_reg;
        sense_en_o       = (state_reg == ST_SENSE1) || (state_reg == ST_SENSE2);
        col_sel_o        = (state_reg == ST_SENSE2);
        buf_write_en_1_o = (state_reg == ST_SENSE1) && last_cycle;
        buf_write_en_2_o = (state_reg == ST_SENSE2) && last_cycle;
        buf_read_en_o    = (state_reg == ST_READ);
        result_o         = result_reg;
        result_valid_o   = (state_reg == ST_DONE);
    end

endmodule

// File: tb/tb_eflash_read_seq.sv
// Bench for eflash_read_seq: an N=4 and an N=1 instance share stimulus, each with an
// eFlash/buffer/encoder environment and an elapsed-time reference model.
module tb_eflash_read_seq;

    localparam int N0 = 4;
    localparam int N1 = 1;

    typedef struct {
        logic       mode;
        logic [7:0] w1;
        logic [7:0] w2;
        int         abort_at;
        logic [6:0] res0;
        int         v0;
        logic [6:0] res1;
        int         v1;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, abort = 1'b0, mode = 1'b0;
    logic busy_w [2], mode_w [2], sense_w [2], col_w [2];
    logic we1_w [2], we2_w [2], rd_w [2], valid_w [2];
    logic [6:0] result_w [2], enc_w [2];
    logic [7:0] w1 [2], w2 [2], sdat [2];
    logic [7:0] buf1 [2] = '{default: '0};
    logic [7:0] buf2 [2] = '{default: '0};
    int   cur [2];
    int   run [2] = '{default: 0};
    bit   pcol [2] = '{default: 1'b0};

    // Reference model state: operation active, elapsed cycles since accept, latched mode, result.
    bit         act [2] = '{default: 1'b0};
    int         t [2] = '{default: 0};
    bit         mlat [2] = '{default: 1'b0};
    logic [6:0] res_m [2] = '{default: '0};

    int n_checks = 0, n_errors = 0;
    bit chk_en = 1'b0;

    eflash_read_seq #(.SENSE_CYCLES(N0), .CNT_W(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .mode_i(mode),
        .encoder_output_i(enc_w[0]), .busy_o(busy_w[0]), .mode_o(mode_w[0]),
        .sense_en_o(sense_w[0]), .col_sel_o(col_w[0]), .buf_write_en_1_o(we1_w[0]),
        .buf_write_en_2_o(we2_w[0]), .buf_read_en_o(rd_w[0]), .result_o(result_w[0]),
        .result_valid_o(valid_w[0]));

    eflash_read_seq #(.SENSE_CYCLES(N1), .CNT_W(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .mode_i(mode),
        .encoder_output_i(enc_w[1]), .busy_o(busy_w[1]), .mode_o(mode_w[1]),
        .sense_en_o(sense_w[1]), .col_sel_o(col_w[1]), .buf_write_en_1_o(we1_w[1]),
        .buf_write_en_2_o(we2_w[1]), .buf_read_en_o(rd_w[1]), .result_o(result_w[1]),
        .result_valid_o(valid_w[1]));

    function automatic int nsense(int d);
        return (d == 0) ? N0 : N1;
    endfunction

    function automatic int popc(logic [7:0] x);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(x[i]);
        return c;
    endfunction

    // Downstream encoder: rbr -> ones count mod 8; parallel -> 8*ones(w1)+ones(w2) mod 128.
    function automatic logic [6:0] enc(logic [7:0] a, logic [7:0] b, logic m);
        int v;
        v = m ? (8 * popc(a) + popc(b)) : (popc(a) % 8);
        return 7'(v % 128);
    endfunction

    assign enc_w[0] = enc(buf1[0], buf2[0], mode_w[0]);
    assign enc_w[1] = enc(buf1[1], buf2[1], mode_w[1]);

    // eFlash model: data is only correct once sense has been held N cycles on one column.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            cur[d] = 0;
            if (sense_w[d] === 1'b1)
                cur[d] = (run[d] > 0 && pcol[d] == col_w[d]) ? run[d] + 1 : 1;
            sdat[d] = (col_w[d] === 1'b1) ? w2[d] : w1[d];
            if (cur[d] < nsense(d)) sdat[d] = ~sdat[d];
        end
    end

    function automatic int lat(int d);
        return nsense(d) * (mlat[d] ? 2 : 1);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            run[d]  <= cur[d];
            pcol[d] <= (col_w[d] === 1'b1);
            if (we1_w[d] === 1'b1) buf1[d] <= sdat[d];
            if (we2_w[d] === 1'b1) buf2[d] <= sdat[d];
            if (rst) begin
                act[d]   <= 1'b0;
                t[d]     <= 0;
                mlat[d]  <= 1'b0;
                res_m[d] <= '0;
            end else if (act[d]) begin
                if (abort || t[d] == lat(d) + 2) begin
                    act[d] <= 1'b0;
                end else begin
                    if (t[d] == lat(d) + 1) res_m[d] <= enc(w1[d], w2[d], mlat[d]);
                    t[d] <= t[d] + 1;
                end
            end else if (start && !abort) begin
                act[d]  <= 1'b1;
                t[d]    <= 1;
                mlat[d] <= mode;
            end
        end
    end

    function automatic logic [14:0] exp_vec(int d);
        int  n, l;
        bit  b, s, c, e1, e2, r, v;
        n  = nsense(d);
        l  = lat(d);
        b  = act[d];
        s  = act[d] && t[d] <= l;
        c  = act[d] && t[d] > n && t[d] <= l;
        e1 = act[d] && t[d] == n;
        e2 = act[d] && mlat[d] && t[d] == 2 * n;
        r  = act[d] && t[d] == l + 1;
        v  = act[d] && t[d] == l + 2;
        return {b, mlat[d], s, c, e1, e2, r, res_m[d], v};
    endfunction

    function automatic logic [14:0] got_vec(int d);
        return {busy_w[d], mode_w[d], sense_w[d], col_w[d], we1_w[d], we2_w[d],
                rd_w[d], result_w[d], valid_w[d]};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++)
                check($sformatf("cycle_outputs_d%0d", d), 32'(got_vec(d)), 32'(exp_vec(d)));
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int vc [2];
        int np [2];
        vc = '{0, 0};
        np = '{0, 0};
        start = 1'b1;
        mode  = v.mode;
        abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            w1[d] = v.w1;
            w2[d] = v.w2;
        end
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (k == v.abort_at);
            mode  = 1'($urandom % 2);
            for (int d = 0; d < 2; d++) begin
                if (valid_w[d] === 1'b1) begin
                    np[d]++;
                    vc[d] = k;
                end
            end
        end
        abort = 1'b0;
        check($sformatf("vec%0d_valid_cycle_d0", idx), vc[0], v.v0);
        check($sformatf("vec%0d_pulses_d0", idx), np[0], (v.v0 != 0) ? 1 : 0);
        check($sformatf("vec%0d_result_d0", idx), 32'(result_w[0]), 32'(v.res0));
        check($sformatf("vec%0d_valid_cycle_d1", idx), vc[1], v.v1);
        check($sformatf("vec%0d_pulses_d1", idx), np[1], (v.v1 != 0) ? 1 : 0);
        check($sformatf("vec%0d_result_d1", idx), 32'(result_w[1]), 32'(v.res1));
        $display("vec %0d: mode=%0d w1=%h w2=%h abort@%0d -> N4 result=%0d valid@%0d, N1 result=%0d valid@%0d",
                 idx, v.mode, v.w1, v.w2, v.abort_at, result_w[0], vc[0], result_w[1], vc[1]);
    endtask

    initial begin
        vec_t vecs [5];
        int   np, vc, accepted;
        bit   mbad;

        vecs[0] = '{mode: 1'b0, w1: 8'hF0, w2: 8'h00, abort_at: 0, res0: 7'd4,  v0: 6,  res1: 7'd4,  v1: 3};
        vecs[1] = '{mode: 1'b1, w1: 8'hE0, w2: 8'hF8, abort_at: 0, res0: 7'd29, v0: 10, res1: 7'd29, v1: 4};
        vecs[2] = '{mode: 1'b1, w1: 8'h0F, w2: 8'h01, abort_at: 6, res0: 7'd29, v0: 0,  res1: 7'd33, v1: 4};
        vecs[3] = '{mode: 1'b1, w1: 8'hFF, w2: 8'hFF, abort_at: 0, res0: 7'd72, v0: 10, res1: 7'd72, v1: 4};
        vecs[4] = '{mode: 1'b0, w1: 8'hFF, w2: 8'h00, abort_at: 0, res0: 7'd0,  v0: 6,  res1: 7'd0,  v1: 3};

        for (int d = 0; d < 2; d++) begin
            w1[d] = 8'h00;
            w2[d] = 8'h00;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_d0", 32'(got_vec(0)), 32'd0);
        check("reset_outputs_d1", 32'(got_vec(1)), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Start pulses while busy and a mid-run mode change must be ignored.
        np = 0;
        mbad = 1'b0;
        start = 1'b1;
        mode = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = (k == 2 || k == 6);
            mode  = (k >= 3);
            if (valid_w[0] === 1'b1) np++;
            if (k <= 6 && mode_w[0] !== 1'b0) mbad = 1'b1;
        end
        start = 1'b0;
        mode  = 1'b0;
        check("busy_single_pulse", np, 1);
        check("busy_mode_held", 32'(mbad), 32'd0);
        $display("busy/mode seq: N4 valid pulses=%0d mode_o=%0d", np, mode_w[0]);

        // Reset in the middle of SENSE1, then an immediate rbr restart.
        for (int d = 0; d < 2; d++) w1[d] = 8'h3C;
        vc = 0;
        start = 1'b1;
        mode = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (k == 3);
            if (k == 4) begin
                check("midrun_reset_d0", 32'(got_vec(0)), 32'd0);
                check("midrun_reset_d1", 32'(got_vec(1)), 32'd0);
                start = 1'b1;
                mode  = 1'b0;
            end
            if (valid_w[0] === 1'b1) vc = k;
        end
        check("reset_restart_valid_cycle", vc, 10);
        check("reset_restart_result", 32'(result_w[0]), 32'd4);
        $display("reset seq: restart valid@%0d result=%0d", vc, result_w[0]);

        // Randomised traffic checked cycle by cycle against the model.
        accepted = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!act[0] && start && !abort && !rst) accepted++;
            rst   = ($urandom % 300 == 0);
            start = ($urandom % 3 == 0);
            abort = ($urandom % 20 == 0);
            mode  = 1'($urandom % 2);
            for (int d = 0; d < 2; d++) begin
                if (!act[d]) begin
                    w1[d] = 8'($urandom);
                    w2[d] = 8'($urandom);
                end
            end
        end
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (20) @(negedge clk);
        $display("random phase: 3000 cycles, about %0d starts offered to idle N4 instance", accepted);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eflash_read_seq.md
Name: eflash_read_seq

Overview:
- Sequencer directly upstream of the eFlash output buffer/encoder stage.
- On a start request it runs one eFlash sense phase in rbr mode, or two in parallel mode.
- It pulses the buffer write enables exactly when the sensed 8-bit word is valid, then asserts the buffer read enable for one cycle.
- It captures the 7-bit encoder result and presents it with a one-cycle valid pulse to the downstream consumer.

Parameters:
- SENSE_CYCLES, default 4: cycles the wordline/sense enable is held per phase before the eFlash output is valid; legal range 1..15.
- CNT_W, default 4: sense counter width; must satisfy 2**CNT_W > SENSE_CYCLES.

Ports:
- clk_i  input  1  single clock; all state changes on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  start request; sampled only in IDLE.
- abort_i  input  1  synchronous abort; returns FSM to IDLE, no result.
- mode_i  input  1  0 = rbr, 1 = parallel; latched on accepted start.
- encoder_output_i  input  7  encoder result, valid in READ cycle.
- busy_o  output  1  high in every state except IDLE.
- mode_o  output  1  latched mode, drives the encoder/buffer stage mode input.
- sense_en_o  output  1  eFlash wordline/sense enable.
- col_sel_o  output  1  0 = first 8-bit word, 1 = second word (parallel only).
- buf_write_en_1_o  output  1  buffer word-1 write strobe.
- buf_write_en_2_o  output  1  buffer word-2 write strobe.
- buf_read_en_o  output  1  buffer read / encoder output enable.
- result_o  output  7  captured encoder result; holds until next capture.
- result_valid_o  output  1  one-cycle pulse when result_o is updated.

Behaviour:
- Reset (rst_i=1 at edge, any state, overrides everything):
  - FSM goes to IDLE; counter = 0.
  - All outputs = 0, including result_o and mode_o.
- States: IDLE, SENSE1, SENSE2, READ, DONE. Encoding is free; registered state, outputs decoded from state/counter.
- IDLE:
  - Outputs low except result_o and mode_o, which hold.
  - start_i=1 and abort_i=0 at an edge: latch mode_o <= mode_i, counter <= 0, go to SENSE1.
- SENSE1: sense_en_o=1, col_sel_o=0, counter increments each cycle.
  - In the cycle where counter == SENSE_CYCLES-1, buf_write_en_1_o=1 (exactly one cycle).
  - Next state is SENSE2 if mode_o=1, else READ; counter resets to 0.
- SENSE2: sense_en_o=1, col_sel_o=1, same counting rule.
  - In the final cycle buf_write_en_2_o=1; next state READ.
- READ, exactly 1 cycle:
  - buf_read_en_o=1; sense_en_o=0; all write strobes 0.
  - result_o <= encoder_output_i at the end of the cycle; next state DONE.
- DONE, exactly 1 cycle: result_valid_o=1; next state IDLE.
- Latency (sampling edge of start = edge 0, N = SENSE_CYCLES):
  - rbr: result_valid_o high in cycle N+2.
  - parallel: result_valid_o high in cycle 2N+2.
  - Next start is accepted at the edge ending DONE+1, i.e. the first IDLE cycle.
- buf_write_en_1_o and buf_write_en_2_o are never high in the same cycle.
  - Neither is high while buf_read_en_o is high.
- start_i while busy_o=1: ignored, not queued.
- mode_i changes mid-operation: ignored; mode_o is stable until the next accepted start.
- abort_i=1 in SENSE1/SENSE2/READ: next state IDLE, all strobes 0 next cycle.
  - result_o is not updated and no result_valid_o pulse is produced.
- abort_i=1 in DONE: result_valid_o still pulses this cycle; next state IDLE.
- abort_i and start_i together in IDLE: abort wins; stays IDLE.
- SENSE_CYCLES=1: each sense phase is one cycle and that cycle carries the write strobe.

Test Plan:
- rbr, N=4:
  - Stimulus: start at edge 0, mode_i=0; eFlash model presents 8'b11110000 while col_sel=0; block wired to the downstream buffer+encoder.
  - Required: sense_en_o in cycles 1-4; buf_write_en_1_o only in cycle 4; buf_read_en_o in cycle 5; result_o=4 with result_valid_o in cycle 6; busy_o low from cycle 7.
- parallel, N=4:
  - Stimulus: start with mode_i=1; word1 = 8'b11100000, word2 = 8'b11111000.
  - Required: write_en_1 in cycle 4; write_en_2 in cycle 8; read in cycle 9; result_o=29 (8*3+5) with valid in cycle 10.
- Busy and mode latch:
  - Stimulus: start pulses in cycles 2 and 6 of an rbr run; mode_i toggled to 1 in cycle 3.
  - Required: no second operation; mode_o stays 0; exactly one result_valid_o pulse.
- Abort:
  - Stimulus: abort_i in cycle 6 of a parallel run (SENSE2).
  - Required: cycle 7 is IDLE with all strobes 0; result_o keeps its previous value (29); no valid pulse.
- Reset:
  - Stimulus: rst_i in cycle 3 of SENSE1.
  - Required: next cycle all outputs 0, including result_o=0 and mode_o=0.
  - A start right after reset release gives normal rbr timing.
- Boundary (SENSE_CYCLES=1 build):
  - rbr with 8'b11111111 gives result_o=0, valid at cycle 3.
  - parallel with 8'b11111111 / 8'b11111111 gives result_o=72 mod 128 = 72, valid at cycle 4.
